// File: rtl/hydra_strand_driver.sv
// LED strand serialiser: WS2801 (clock + data) or WS2811 (single-wire NRZ), pixels read from RAM.
// Walks current_idx 0..length-1, shifts each 24-bit pixel MSB first, then holds the latch gap.
module hydra_strand_driver #(
  parameter int MEM_DATA_WIDTH     = 24,
  parameter int STRAND_PARAM_WIDTH = 16,
  parameter int WS2811_T0H         = 20,
  parameter int WS2811_T1H         = 40,
  parameter int WS2811_TBIT        = 63,
  parameter int WS2811_TRESET      = 2600,
  parameter int WS2801_THALF       = 25,
  parameter int WS2801_TLATCH      = 25000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ws2811_mode,
  input  logic [STRAND_PARAM_WIDTH-1:0] strand_length,
  output logic [STRAND_PARAM_WIDTH-1:0] current_idx,
  input  logic [MEM_DATA_WIDTH-1:0]     mem_data,
  input  logic                          start_frame,
  output logic                          busy,
  output logic                          done,
  output logic                          strand_clk,
  output logic                          strand_data
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int TMAX = max2(max2(WS2811_TRESET, WS2801_TLATCH),
                             max2(WS2811_TBIT, 2 * WS2801_THALF));
  localparam int TW = $clog2(TMAX + 1);
  localparam int BW = (MEM_DATA_WIDTH > 1) ? $clog2(MEM_DATA_WIDTH) : 1;

  localparam logic [TW-1:0] T_2811_END   = TW'(WS2811_TBIT - 1);
  // Last bit of a non-final pixel is cut short so FETCH+LOAD fill out its low phase.
  localparam logic [TW-1:0] T_2811_SHORT = TW'(WS2811_TBIT - 3);
  localparam logic [TW-1:0] T_2801_END   = TW'(2 * WS2801_THALF - 1);
  localparam logic [TW-1:0] T_RST_END    = TW'(WS2811_TRESET - 1);
  localparam logic [TW-1:0] T_LAT_END    = TW'(WS2801_TLATCH - 1);
  localparam logic [TW-1:0] T_T0H        = TW'(WS2811_T0H);
  localparam logic [TW-1:0] T_T1H        = TW'(WS2811_T1H);
  localparam logic [TW-1:0] T_HALF       = TW'(WS2801_THALF);
  localparam logic [BW-1:0] BIT_TOP      = BW'(MEM_DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]                    state_q, state_d;
  logic                          mode_q, mode_d;
  logic [STRAND_PARAM_WIDTH-1:0] len_q, len_d;
  logic [STRAND_PARAM_WIDTH-1:0] idx_q, idx_d;
  logic [MEM_DATA_WIDTH-1:0]     sreg_q, sreg_d;
  logic [BW-1:0]                 bit_q, bit_d;
  logic [TW-1:0]                 t_q, t_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          sclk_q, sclk_d;
  logic                          sdat_q, sdat_d;

  logic last_pix;
  logic bit_end;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    len_d    = len_q;
    idx_d    = idx_q;
    sreg_d   = sreg_q;
    bit_d    = bit_q;
    t_d      = t_q;
    last_pix = (idx_q == (len_q - STRAND_PARAM_WIDTH'(1)));
    bit_end  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_frame) begin
          mode_d  = ws2811_mode;
          len_d   = strand_length;
          idx_d   = '0;
          t_d     = '0;
          state_d = (strand_length == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        sreg_d  = mem_data;
        bit_d   = BIT_TOP;
        t_d     = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (mode_q) begin
          bit_end = (bit_q == '0 && !last_pix) ? (t_q == T_2811_SHORT) : (t_q == T_2811_END);
        end else begin
          bit_end = (t_q == T_2801_END);
        end
        if (bit_end) begin
          t_d = '0;
          if (bit_q == '0) begin
            if (last_pix) begin
              state_d = S_LATCH;
            end else begin
              idx_d   = idx_q + STRAND_PARAM_WIDTH'(1);
              state_d = S_FETCH;
            end
          end else begin
            bit_d  = bit_q - BW'(1);
            sreg_d = sreg_q << 1;
          end
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      S_LATCH: begin
        if (t_q == (mode_q ? T_RST_END : T_LAT_END)) begin
          state_d = S_DONE;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered: derive them from the next-cycle state and timer.
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
    sdat_d = 1'b0;
    sclk_d = 1'b0;
    if (state_d == S_SHIFT) begin
      if (mode_d) begin
        sdat_d = (t_d < (sreg_d[MEM_DATA_WIDTH-1] ? T_T1H : T_T0H));
      end else begin
        sdat_d = sreg_d[MEM_DATA_WIDTH-1];
        sclk_d = (t_d >= T_HALF);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      len_q   <= '0;
      idx_q   <= '0;
      sreg_q  <= '0;
      bit_q   <= '0;
      t_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sdat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      sreg_q  <= sreg_d;
      bit_q   <= bit_d;
      t_q     <= t_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      sdat_q  <= sdat_d;
    end
  end

  assign current_idx = idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign strand_clk  = sclk_q;
  assign strand_data = sdat_q;

endmodule

// File: tb/tb_hydra_strand_driver.sv
// Directed bench for hydra_strand_driver with shortened timing parameters.
// Outputs sampled on the falling edge; inputs driven on the falling edge.
module tb_hydra_strand_driver;

  localparam int P_T0H    = 2;
  localparam int P_T1H    = 4;
  localparam int P_TBIT   = 7;
  localparam int P_TRESET = 20;
  localparam int P_THALF  = 3;
  localparam int P_TLATCH = 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ws2811_mode = 1'b0;
  logic [15:0] strand_length = 16'd0;
  logic [15:0] current_idx;
  logic [23:0] mem_data;
  logic        start_frame = 1'b0;
  logic        busy, done, strand_clk, strand_data;
  logic [23:0] pix_val = 24'h0;

  int n_assert = 0;
  int n_fail   = 0;

  hydra_strand_driver #(
    .MEM_DATA_WIDTH(24), .STRAND_PARAM_WIDTH(16),
    .WS2811_T0H(P_T0H), .WS2811_T1H(P_T1H), .WS2811_TBIT(P_TBIT),
    .WS2811_TRESET(P_TRESET), .WS2801_THALF(P_THALF), .WS2801_TLATCH(P_TLATCH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ws2811_mode(ws2811_mode), .strand_length(strand_length),
    .current_idx(current_idx), .mem_data(mem_data), .start_frame(start_frame),
    .busy(busy), .done(done), .strand_clk(strand_clk), .strand_data(strand_data)
  );

  always #10 clk = ~clk;

  // Pixel memory with one-cycle read latency.
  always @(posedge clk) mem_data <= pix_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  initial begin : main
    int cyc, prev_d, prev_c, hi, k, last_rise, nrise, nfall, w_err, p_err;
    int idx_err, idx_steps, clk_err, done_cyc, done_cnt, busy_at_done;
    int w0, w8, w16, w17, n6, n8, dat_err, hold_err, found, act;
    logic [15:0] prev_idx;
    logic ebit;

    // Reset
    repeat (2) @(negedge clk);
    check("rst_idx", current_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_clk", strand_clk, 0);
    check("rst_data", strand_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // WS2811 frame, 160 pixels of 0xFF0055, with an ignored re-start mid-frame
    pix_val = 24'hFF0055; ws2811_mode = 1'b1; strand_length = 16'd160; start_frame = 1'b1;
    @(negedge clk);
    start_frame = 1'b0;
    check("ws2811_busy_after_start", busy, 1);
    check("ws2811_idx_start", current_idx, 0);
    cyc = 0; prev_d = 0; hi = 0; last_rise = 0; nrise = 0; nfall = 0; w_err = 0; p_err = 0;
    idx_err = 0; idx_steps = 0; clk_err = 0; done_cyc = 0; done_cnt = 0; busy_at_done = 0;
    w0 = 0; w8 = 0; w16 = 0; w17 = 0; prev_idx = current_idx;
    while (done_cnt == 0 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 500) begin
        start_frame = 1'b1; ws2811_mode = 1'b0; strand_length = 16'd5;
      end
      if (cyc == 501) start_frame = 1'b0;
      if (strand_clk !== 1'b0) clk_err++;
      if (strand_data === 1'b1 && prev_d == 0) begin
        if (nrise > 0 && (cyc - last_rise) != P_TBIT) p_err++;
        last_rise = cyc;
        nrise++;
        hi = 0;
      end
      if (strand_data === 1'b1) hi++;
      if (strand_data === 1'b0 && prev_d == 1) begin
        k = nfall % 24;
        ebit = pix_val[23-k];
        if (hi != (ebit ? P_T1H : P_T0H)) w_err++;
        if (nfall == 0)  w0 = hi;
        if (nfall == 8)  w8 = hi;
        if (nfall == 16) w16 = hi;
        if (nfall == 17) w17 = hi;
        nfall++;
      end
      prev_d = (strand_data === 1'b1) ? 1 : 0;
      if (current_idx !== prev_idx) begin
        if (current_idx !== prev_idx + 16'd1) idx_err++;
        idx_steps++;
        prev_idx = current_idx;
      end
      if (done === 1'b1) begin
        done_cnt++; done_cyc = cyc; busy_at_done = busy;
      end
    end
    check("ws2811_done_seen", done_cnt, 1);
    check("ws2811_rises", nrise, 3840);
    check("ws2811_falls", nfall, 3840);
    check("ws2811_width_errors", w_err, 0);
    check("ws2811_period_errors", p_err, 0);
    check("ws2811_w_bit1", w0, P_T1H);
    check("ws2811_w_bit9", w8, P_T0H);
    check("ws2811_w_bit17", w16, P_T0H);
    check("ws2811_w_bit18", w17, P_T1H);
    check("ws2811_idx_errors", idx_err, 0);
    check("ws2811_idx_steps", idx_steps, 159);
    check("ws2811_idx_final", current_idx, 159);
    check("ws2811_done_gap", done_cyc - last_rise, P_TBIT + P_TRESET);
    check("ws2811_busy_at_done", busy_at_done, 0);
    check("ws2811_clk_quiet", clk_err, 0);
    @(negedge clk);
    check("ws2811_done_single", done, 0);
    check("ws2811_busy_after", busy, 0);
    check("ws2811_idx_hold", current_idx, 159);

    // WS2801 frame, 2 pixels of 0xA5A5A5
    pix_val = 24'hA5A5A5; ws2811_mode = 1'b0; strand_length = 16'd2; start_frame = 1'b1;
    @(negedge clk);
    start_frame = 1'b0;
    check("ws2801_busy_after_start", busy, 1);
    cyc = 0; prev_c = 0; prev_d = 0; nrise = 0; last_rise = 0; n6 = 0; n8 = 0; p_err = 0;
    dat_err = 0; hold_err = 0; done_cnt = 0; done_cyc = 0;
    while (done_cnt == 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (strand_clk === 1'b1 && prev_c == 0) begin
        k = nrise % 24;
        ebit = pix_val[23-k];
        if (strand_data !== ebit) dat_err++;
        if (nrise > 0) begin
          if ((cyc - last_rise) == 2 * P_THALF) n6++;
          else if ((cyc - last_rise) == 2 * P_THALF + 2) n8++;
          else p_err++;
        end
        last_rise = cyc;
        nrise++;
      end
      if (strand_clk === 1'b1 && prev_c == 1 && ((strand_data === 1'b1) ? 1 : 0) != prev_d) hold_err++;
      prev_c = (strand_clk === 1'b1) ? 1 : 0;
      prev_d = (strand_data === 1'b1) ? 1 : 0;
      if (done === 1'b1) begin
        done_cnt++; done_cyc = cyc;
      end
    end
    check("ws2801_done_seen", done_cnt, 1);
    check("ws2801_rises", nrise, 48);
    check("ws2801_data_errors", dat_err, 0);
    check("ws2801_hold_errors", hold_err, 0);
    check("ws2801_bit_periods", n6, 46);
    check("ws2801_pixel_gap_periods", n8, 1);
    check("ws2801_period_errors", p_err, 0);
    check("ws2801_latch_gap", done_cyc - last_rise, P_THALF + P_TLATCH);
    check("ws2801_idx_final", current_idx, 1);
    @(negedge clk);
    check("ws2801_done_single", done, 0);

    // Zero-length frame
    strand_length = 16'd0; ws2811_mode = 1'b0; start_frame = 1'b1;
    found = 0; act = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start_frame = 1'b0;
      if (done === 1'b1) found++;
      if (strand_data !== 1'b0 || strand_clk !== 1'b0) act++;
    end
    check("len0_done_pulse", found, 1);
    check("len0_no_activity", act, 0);

    // Reset in the middle of a WS2801 frame
    strand_length = 16'd3; pix_val = 24'hA5A5A5; start_frame = 1'b1;
    @(negedge clk);
    start_frame = 1'b0;
    repeat (200) @(negedge clk);
    check("midrst_busy_before", busy, 1);
    check("midrst_idx_before", current_idx, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_idx", current_idx, 0);
    check("midrst_busy", busy, 0);
    check("midrst_clk", strand_clk, 0);
    check("midrst_data", strand_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    found = 0; act = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) found++;
      if (busy !== 1'b0) act++;
    end
    check("midrst_no_done", found, 0);
    check("midrst_stays_idle", act, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
